dm_stage: RTL

- Data-memory block of the M stage in the 5-stage MIPS pipeline; sits between the EX/MEM register and the MEM/WB register.
- Performs word, half and byte loads and stores against an on-chip word-addressed RAM.
- Produces the sign- or zero-extended load data that the MEM/WB register latches.
- After reset, sweeps the RAM to zero and asserts busy so the hazard unit stalls the pipeline until the memory is clean.

---
 rtl/dm_stage_pkg.sv | 33 +++
 rtl/dm_stage_if.sv | 15 +
 rtl/dm_stage_load_ext.sv | 41 ++++
 rtl/dm_stage.sv | 117 +++++++++++
 4 files changed

// File: rtl/dm_stage_pkg.sv
// Shared CPU definitions: data-memory op encoding, M-stage memory FSM states
// and the default RAM size. Imported by the data-memory stage and its bench.
package cpu_defs;

  typedef enum logic [3:0] {
    MEM_NONE = 4'd0,
    MEM_LW   = 4'd1,
    MEM_LH   = 4'd2,
    MEM_LHU  = 4'd3,
    MEM_LB   = 4'd4,
    MEM_LBU  = 4'd5,
    MEM_SW   = 4'd6,
    MEM_SH   = 4'd7,
    MEM_SB   = 4'd8
  } mem_op_e;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } dm_state_e;

  localparam int DM_ADDR_W_DEF = 12;

  function automatic logic op_is_load(input logic [3:0] op);
    return (op == MEM_LW) || (op == MEM_LH) || (op == MEM_LHU) ||
           (op == MEM_LB) || (op == MEM_LBU);
  endfunction

  function automatic logic op_is_store(input logic [3:0] op);
    return (op == MEM_SW) || (op == MEM_SH) || (op == MEM_SB);
  endfunction

endpackage

// File: rtl/dm_stage_if.sv
// Pipeline-to-data-memory bus: EX/MEM drives the request, M stage returns
// load data plus the busy/addr_err status used by the hazard unit.
interface dm_stage_if;
  logic [3:0]  mem_op;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        busy;
  logic        addr_err;

  modport master (output mem_op, output addr, output wdata,
                  input rdata, input busy, input addr_err);
  modport slave  (input mem_op, input addr, input wdata,
                  output rdata, output busy, output addr_err);
endinterface

// File: rtl/dm_stage_load_ext.sv
// Load alignment: picks the addressed byte/half out of a RAM word and
// sign- or zero-extends it to 32 bits. Non-load ops produce 0.
module load_ext
  import cpu_defs::*;
(
  input  logic [31:0] i_word,
  input  logic [1:0]  i_bsel,
  input  logic [3:0]  i_mem_op,
  output logic [31:0] o_data
);

  logic [15:0] w_half;
  logic [7:0]  w_byte;

  function automatic logic [31:0] ext_half(input logic [15:0] v, input logic sgn);
    logic signed [15:0] s;
    s = v;
    return sgn ? {{16{s[15]}}, v} : {16'h0000, v};
  endfunction

  function automatic logic [31:0] ext_byte(input logic [7:0] v, input logic sgn);
    logic signed [7:0] s;
    s = v;
    return sgn ? {{24{s[7]}}, v} : {24'h000000, v};
  endfunction

  always_comb begin
    w_half = i_bsel[1] ? i_word[31:16] : i_word[15:0];
    w_byte = i_word[{i_bsel, 3'b000} +: 8];
    o_data = '0;
    case (i_mem_op)
      MEM_LW:  o_data = i_word;
      MEM_LH:  o_data = ext_half(w_half, 1'b1);
      MEM_LHU: o_data = ext_half(w_half, 1'b0);
      MEM_LB:  o_data = ext_byte(w_byte, 1'b1);
      MEM_LBU: o_data = ext_byte(w_byte, 1'b0);
      default: o_data = '0;
    endcase
  end

endmodule

// File: rtl/dm_stage.sv
// M-stage data memory: word-addressed RAM with byte-enable stores, zero-latency
// extended loads, and a post-reset zeroing sweep that holds busy high.
module dm_stage
  import cpu_defs::*;
#(
  parameter int          ADDR_W = DM_ADDR_W_DEF,
  parameter logic [31:0] BASE   = 32'h0000_0000
) (
  input logic         clk,
  input logic         reset,
  dm_stage_if.slave   bus
);

  localparam int DEPTH = 2 ** ADDR_W;

  dm_state_e          r_state;
  dm_state_e          w_state_nxt;
  logic [ADDR_W-1:0]  r_clear_ptr;
  logic [31:0]        r_mem [DEPTH];

  logic [31:0]        w_off;
  logic [ADDR_W-1:0]  w_widx;
  logic               w_run;
  logic               w_is_ld;
  logic               w_is_st;
  logic               w_oor;
  logic               w_mis;
  logic               w_err;
  logic               w_we;
  logic [3:0]         w_be;
  logic [31:0]        w_lane;
  logic [31:0]        w_rword;
  logic [31:0]        w_ld;

  // Addresses below BASE wrap to huge offsets and so land in the out-of-range check.
  assign w_off   = bus.addr - BASE;
  assign w_widx  = w_off[ADDR_W+1:2];
  assign w_oor   = |w_off[31:ADDR_W+2];
  assign w_is_ld = op_is_load(bus.mem_op);
  assign w_is_st = op_is_store(bus.mem_op);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= ST_CLEAR;
      r_clear_ptr <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == ST_CLEAR) r_clear_ptr <= r_clear_ptr + 1'b1;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_CLEAR: if (r_clear_ptr == {ADDR_W{1'b1}}) w_state_nxt = ST_RUN;
      default:  w_state_nxt = ST_RUN;
    endcase
  end

  always_comb begin
    bus.busy = (r_state == ST_CLEAR);
    w_run    = (r_state == ST_RUN);
  end

  always_comb begin
    w_mis = 1'b0;
    case (bus.mem_op)
      MEM_LW, MEM_SW:          w_mis = (bus.addr[1:0] != 2'b00);
      MEM_LH, MEM_LHU, MEM_SH: w_mis = bus.addr[0];
      default:                 w_mis = 1'b0;
    endcase
    w_err = w_run && (w_is_ld || w_is_st) && (w_mis || w_oor);
    w_we  = w_run && w_is_st && !w_err;
  end

  // Store data is replicated across lanes so the byte enables alone pick the target bytes.
  always_comb begin
    w_be   = 4'b0000;
    w_lane = bus.wdata;
    case (bus.mem_op)
      MEM_SW: w_be = 4'b1111;
      MEM_SH: begin
        w_be   = bus.addr[1] ? 4'b1100 : 4'b0011;
        w_lane = {2{bus.wdata[15:0]}};
      end
      MEM_SB: begin
        w_be   = 4'b0001 << bus.addr[1:0];
        w_lane = {4{bus.wdata[7:0]}};
      end
      default: w_be = 4'b0000;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      if (r_state == ST_CLEAR) begin
        r_mem[r_clear_ptr] <= '0;
      end else if (w_we) begin
        for (int b = 0; b < 4; b++)
          if (w_be[b]) r_mem[w_widx][8*b +: 8] <= w_lane[8*b +: 8];
      end
    end
  end

  assign w_rword = r_mem[w_widx];

  load_ext u_load_ext (
    .i_word   (w_rword),
    .i_bsel   (bus.addr[1:0]),
    .i_mem_op (bus.mem_op),
    .o_data   (w_ld)
  );

  assign bus.rdata    = (w_run && w_is_ld && !w_err) ? w_ld : 32'h0000_0000;
  assign bus.addr_err = w_err;

endmodule
